// File: rtl/decode_exec_pipe.sv
// ---------------------------------------------------------------------------
// decode_exec_pipe
//   Decode -> execute boundary of the pipelined RV32I core. Holds the opaque
//   decoded bundle plus the rd/load sideband needed for hazard detection,
//   handshaked with valid/ready on both sides.
//
//   SKID=1 : main + skid entry, o_d_ready depends on registered state only.
//   SKID=0 : single main entry, o_d_ready passes i_e_ready through.
//
//   Also hosts the load-use interlock, branch/jump flush and two saturating
//   performance counters (interlock stall cycles, entries killed by flush).
//
// Ports
//   i_clk, i_rst           clock (rising edge), synchronous active-high reset
//   i_flush                kill held entries, drop this cycle's input
//   i_d_valid/o_d_ready    decode-side handshake
//   i_d_payload            decoded bundle
//   i_d_rs1/rs2_addr,_use  sources of the incoming instruction
//   i_d_rd_addr/_wren      destination of the incoming instruction
//   i_d_is_load            incoming instruction is a load
//   o_e_valid/i_e_ready    execute-side handshake
//   o_e_payload, o_e_rd_addr, o_e_rd_wren, o_e_is_load   oldest held entry
//   o_hazard               load-use interlock active this cycle
//   o_stall_cnt            saturating count of interlock cycles
//   o_flush_cnt            saturating count of valid entries killed by flush
// ---------------------------------------------------------------------------
module decode_exec_pipe #(
    parameter int PAYLOAD_W = 160,
    parameter int SKID      = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_d_valid,
    output logic                 o_d_ready,
    input  logic [PAYLOAD_W-1:0] i_d_payload,
    input  logic [4:0]           i_d_rs1_addr,
    input  logic [4:0]           i_d_rs2_addr,
    input  logic                 i_d_rs1_use,
    input  logic                 i_d_rs2_use,
    input  logic [4:0]           i_d_rd_addr,
    input  logic                 i_d_rd_wren,
    input  logic                 i_d_is_load,
    output logic                 o_e_valid,
    input  logic                 i_e_ready,
    output logic [PAYLOAD_W-1:0] o_e_payload,
    output logic [4:0]           o_e_rd_addr,
    output logic                 o_e_rd_wren,
    output logic                 o_e_is_load,
    output logic                 o_hazard,
    output logic [CNT_W-1:0]     o_stall_cnt,
    output logic [CNT_W-1:0]     o_flush_cnt
);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [4:0]           rd_addr;
        logic                 rd_wren;
        logic                 is_load;
    } entry_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    entry_t           main_q, main_d, skid_q, skid_d, in_entry, young;
    logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             hazard, accept, consume, young_valid;
    logic [1:0]       flush_inc;

    assign in_entry = '{payload: i_d_payload, rd_addr: i_d_rd_addr,
                        rd_wren: i_d_rd_wren, is_load: i_d_is_load};

    // The youngest held entry is the one an incoming instruction depends on.
    assign young_valid = main_valid_q | skid_valid_q;
    assign young       = skid_valid_q ? skid_q : main_q;

    assign hazard = i_d_valid && young_valid && young.is_load && young.rd_wren &&
                    (young.rd_addr != 5'd0) &&
                    ((i_d_rs1_use && (i_d_rs1_addr == young.rd_addr)) ||
                     (i_d_rs2_use && (i_d_rs2_addr == young.rd_addr)));

    generate
        if (SKID != 0) begin : g_ready_skid
            assign o_d_ready = !skid_valid_q && !hazard;
        end else begin : g_ready_pass
            assign o_d_ready = (!main_valid_q || i_e_ready) && !hazard;
        end
    endgenerate

    assign accept  = i_d_valid && o_d_ready && !i_flush;
    assign consume = main_valid_q && i_e_ready;

    // Entries still held at a flush edge; a same-cycle consume is not a kill.
    assign flush_inc = {1'b0, main_valid_q && !i_e_ready} + {1'b0, skid_valid_q};

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (i_flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                // TWO -> ONE: skid promotes; ready was low so nothing accepted.
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = in_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Only reachable with main full when SKID=1 (SKID=0 ready blocks it).
            if (main_valid_q) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (hazard && !i_flush) begin
            stall_d = sat_add(stall_q, 2'd1);
        end
        if (i_flush) begin
            flush_d = sat_add(flush_q, flush_inc);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_q      <= '0;
            flush_q      <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
        end
    end

    assign o_e_valid   = main_valid_q;
    assign o_e_payload = main_q.payload;
    assign o_e_rd_addr = main_q.rd_addr;
    assign o_e_rd_wren = main_q.rd_wren;
    assign o_e_is_load = main_q.is_load;
    assign o_hazard    = hazard;
    assign o_stall_cnt = stall_q;
    assign o_flush_cnt = flush_q;

endmodule

// File: tb/tb_decode_exec_pipe.sv
module tb_decode_exec_pipe;

    localparam int PW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          d_valid = 1'b0;
    logic          d_ready;
    logic [PW-1:0] d_payload = '0;
    logic [4:0]    rs1 = '0, rs2 = '0, rd = '0;
    logic          rs1_use = 1'b0, rs2_use = 1'b0, rd_wren = 1'b0, is_load = 1'b0;
    logic          e_valid;
    logic          e_ready = 1'b0;
    logic [PW-1:0] e_payload;
    logic [4:0]    e_rd;
    logic          e_wren, e_load, hazard;
    logic [CW-1:0] stall_cnt, flush_cnt;

    logic          d_valid0 = 1'b0;
    logic          d_ready0;
    logic [PW-1:0] d_payload0 = '0;
    logic          e_valid0;
    logic          e_ready0 = 1'b0;
    logic [PW-1:0] e_payload0;
    logic [4:0]    e_rd0;
    logic          e_wren0, e_load0, hazard0;
    logic [CW-1:0] stall_cnt0, flush_cnt0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_exec_pipe #(.PAYLOAD_W(PW), .SKID(1), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_d_valid(d_valid), .o_d_ready(d_ready), .i_d_payload(d_payload),
        .i_d_rs1_addr(rs1), .i_d_rs2_addr(rs2), .i_d_rs1_use(rs1_use), .i_d_rs2_use(rs2_use),
        .i_d_rd_addr(rd), .i_d_rd_wren(rd_wren), .i_d_is_load(is_load),
        .o_e_valid(e_valid), .i_e_ready(e_ready), .o_e_payload(e_payload),
        .o_e_rd_addr(e_rd), .o_e_rd_wren(e_wren), .o_e_is_load(e_load),
        .o_hazard(hazard), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    decode_exec_pipe #(.PAYLOAD_W(PW), .SKID(0), .CNT_W(CW)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_flush(1'b0),
        .i_d_valid(d_valid0), .o_d_ready(d_ready0), .i_d_payload(d_payload0),
        .i_d_rs1_addr(5'd0), .i_d_rs2_addr(5'd0), .i_d_rs1_use(1'b0), .i_d_rs2_use(1'b0),
        .i_d_rd_addr(5'd0), .i_d_rd_wren(1'b0), .i_d_is_load(1'b0),
        .o_e_valid(e_valid0), .i_e_ready(e_ready0), .o_e_payload(e_payload0),
        .o_e_rd_addr(e_rd0), .o_e_rd_wren(e_wren0), .o_e_is_load(e_load0),
        .o_hazard(hazard0), .o_stall_cnt(stall_cnt0), .o_flush_cnt(flush_cnt0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [PW-1:0] p, input logic [4:0] d, input logic w,
                          input logic ld, input logic [4:0] s1, input logic u1,
                          input logic [4:0] s2, input logic u2);
        d_valid = 1'b1; d_payload = p; rd = d; rd_wren = w; is_load = ld;
        rs1 = s1; rs1_use = u1; rs2 = s2; rs2_use = u2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL reset_e_valid: got %b expected 0", e_valid); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL reset_d_ready: got %b expected 1", d_ready); end
        checks++; if (e_payload !== '0) begin errors++; $display("FAIL reset_payload: got %h expected 0", e_payload); end
        checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        checks++; if (e_valid0 !== 1'b0) begin errors++; $display("FAIL reset_e_valid_skid0: got %b expected 0", e_valid0); end
    endtask

    task automatic test_stream();
        e_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_in(32'hA000_0000 + k, 5'(k + 1), 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            #1;
            checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", k, d_ready); end
            step();
            checks++; if (e_valid !== 1'b1 || e_payload !== 32'hA000_0000 + k) begin errors++; $display("FAIL stream_out[%0d]: got v=%b %h expected v=1 %h", k, e_valid, e_payload, 32'hA000_0000 + k); end
            checks++; if (e_rd !== 5'(k + 1)) begin errors++; $display("FAIL stream_rd[%0d]: got %0d expected %0d", k, e_rd, k + 1); end
        end
        d_valid = 1'b0;
        step();
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", e_valid); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        e_ready = 1'b0;
        set_in(32'hB000_000A, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_empty: got %b expected 1", d_ready); end
        step();
        checks++; if (e_valid !== 1'b1 || e_payload !== 32'hB000_000A) begin errors++; $display("FAIL bp_first: got v=%b %h expected v=1 b000000a", e_valid, e_payload); end
        set_in(32'hB000_000B, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b expected 1", d_ready); end
        step();
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_two: got %b expected 0", d_ready); end
        checks++; if (e_payload !== 32'hB000_000A) begin errors++; $display("FAIL bp_hold1: got %h expected b000000a", e_payload); end
        set_in(32'hB000_000C, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        checks++; if (e_payload !== 32'hB000_000A || e_rd !== 5'd10) begin errors++; $display("FAIL bp_hold2: got %h rd=%0d expected b000000a rd=10", e_payload, e_rd); end
        e_ready = 1'b1;
        #1;
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_registered: got %b expected 0", d_ready); end
        step();
        checks++; if (e_valid !== 1'b1 || e_payload !== 32'hB000_000B) begin errors++; $display("FAIL bp_drain_b: got v=%b %h expected v=1 b000000b", e_valid, e_payload); end
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", d_ready); end
        step();
        checks++; if (e_valid !== 1'b1 || e_payload !== 32'hB000_000C) begin errors++; $display("FAIL bp_drain_c: got v=%b %h expected v=1 b000000c", e_valid, e_payload); end
        d_valid = 1'b0;
        step();
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", e_valid); end
    endtask

    task automatic test_load_use();
        e_ready = 1'b1;
        set_in(32'h1D00_0005, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        checks++; if (e_valid !== 1'b1 || e_load !== 1'b1 || e_rd !== 5'd5 || e_wren !== 1'b1) begin errors++; $display("FAIL lu_load_in_e: got v=%b ld=%b rd=%0d w=%b expected 1 1 5 1", e_valid, e_load, e_rd, e_wren); end
        set_in(32'hADD0_0006, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1);
        #1;
        checks++; if (hazard !== 1'b1 || d_ready !== 1'b0) begin errors++; $display("FAIL lu_hazard_on: got hz=%b rdy=%b expected 1 0", hazard, d_ready); end
        step();
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b expected 0", e_valid); end
        checks++; if (hazard !== 1'b0 || d_ready !== 1'b1) begin errors++; $display("FAIL lu_hazard_off: got hz=%b rdy=%b expected 0 1", hazard, d_ready); end
        step();
        checks++; if (e_valid !== 1'b1 || e_payload !== 32'hADD0_0006) begin errors++; $display("FAIL lu_add_out: got v=%b %h expected v=1 add00006", e_valid, e_payload); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
        set_in(32'h1D00_0000, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_in(32'hADD0_0000, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL lu_x0_hazard: got %b expected 0", hazard); end
        step();
        checks++; if (e_valid !== 1'b1 || e_payload !== 32'hADD0_0000) begin errors++; $display("FAIL lu_x0_add: got v=%b %h expected v=1 add00000", e_valid, e_payload); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_x0_stall_cnt: got %0d expected 1", stall_cnt); end
        d_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        e_ready = 1'b0;
        set_in(32'hF000_0001, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_in(32'hF000_0002, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_in(32'hF000_0003, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0; d_valid = 1'b0;
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL flush_two_valid: got %b expected 0", e_valid); end
        checks++; if (flush_cnt !== 4'd2) begin errors++; $display("FAIL flush_two_cnt: got %0d expected 2", flush_cnt); end
        step();
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL flush_input_dropped: got %b expected 0", e_valid); end
        set_in(32'hF000_0004, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        e_ready = 1'b1; flush = 1'b1;
        set_in(32'hF000_0005, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        flush = 1'b0; d_valid = 1'b0;
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL flush_one_valid: got %b expected 0", e_valid); end
        checks++; if (flush_cnt !== 4'd2) begin errors++; $display("FAIL flush_consumed_not_counted: got %0d expected 2", flush_cnt); end
    endtask

    task automatic test_reset_mid();
        e_ready = 1'b0;
        set_in(32'hC000_0001, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_in(32'hC000_0002, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_in(32'hC000_0003, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1; flush = 1'b1;
        step();
        checks++; if (e_valid !== 1'b0 || e_payload !== '0 || e_rd !== 5'd0 || e_wren !== 1'b0 || e_load !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got v=%b %h rd=%0d w=%b ld=%b expected all 0", e_valid, e_payload, e_rd, e_wren, e_load); end
        checks++; if (hazard !== 1'b0 || d_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got hz=%b rdy=%b expected 0 1", hazard, d_ready); end
        checks++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        rst = 1'b0; flush = 1'b0; d_valid = 1'b0;
        step();
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %b expected 0", e_valid); end
    endtask

    task automatic test_saturation();
        e_ready = 1'b0;
        set_in(32'h5A70_0009, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        set_in(32'h5A70_000A, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            step();
            if (i == 4) begin
                checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL sat_midway: got %0d expected 5", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_stall_cnt: got %0d expected 15", stall_cnt); end
        checks++; if (hazard !== 1'b1 || e_payload !== 32'h5A70_0009) begin errors++; $display("FAIL sat_still_held: got hz=%b %h expected 1 5a700009", hazard, e_payload); end
        flush = 1'b1;
        step();
        flush = 1'b0; d_valid = 1'b0;
        checks++; if (flush_cnt !== 4'd1 || e_valid !== 1'b0) begin errors++; $display("FAIL sat_flush: got cnt=%0d v=%b expected 1 0", flush_cnt, e_valid); end
    endtask

    task automatic test_skid0();
        e_ready0 = 1'b0;
        d_valid0 = 1'b1; d_payload0 = 32'h5000_0000;
        #1;
        checks++; if (d_ready0 !== 1'b1) begin errors++; $display("FAIL s0_ready_empty: got %b expected 1", d_ready0); end
        step();
        checks++; if (e_valid0 !== 1'b1 || e_payload0 !== 32'h5000_0000) begin errors++; $display("FAIL s0_first: got v=%b %h expected v=1 50000000", e_valid0, e_payload0); end
        for (int k = 1; k <= 4; k++) begin
            d_payload0 = 32'h5000_0000 + k;
            e_ready0 = 1'b0;
            #1;
            checks++; if (d_ready0 !== 1'b0) begin errors++; $display("FAIL s0_ready_low[%0d]: got %b expected 0", k, d_ready0); end
            step();
            checks++; if (e_payload0 !== 32'h5000_0000 + k - 1) begin errors++; $display("FAIL s0_hold[%0d]: got %h expected %h", k, e_payload0, 32'h5000_0000 + k - 1); end
            e_ready0 = 1'b1;
            #1;
            checks++; if (d_ready0 !== 1'b1) begin errors++; $display("FAIL s0_ready_high[%0d]: got %b expected 1", k, d_ready0); end
            step();
            checks++; if (e_valid0 !== 1'b1 || e_payload0 !== 32'h5000_0000 + k) begin errors++; $display("FAIL s0_next[%0d]: got v=%b %h expected v=1 %h", k, e_valid0, e_payload0, 32'h5000_0000 + k); end
        end
        d_valid0 = 1'b0;
        step();
        checks++; if (e_valid0 !== 1'b0) begin errors++; $display("FAIL s0_drain: got %b expected 0", e_valid0); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_load_use();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_skid0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_exec_pipe.md
Name: decode_exec_pipe

Overview:
- Parametrised decode→execute boundary for the pipelined RV32I core, replacing a fixed enable/clear D/E register.
- Carries an opaque decoded bundle (control, immediate, operands, PC) under a valid/ready handshake, with an optional 2-entry skid buffer.
- Adds in-block load-use interlock, branch/jump flush, and saturating stall/flush performance counters.

Parameters:
PAYLOAD_W, 160, width of the opaque decoded bundle passed D→E
SKID, 1, 0 = single register with combinational ready; 1 = 2-entry skid buffer with registered ready
CNT_W, 16, width of the saturating performance counters

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous active-high reset
i_flush  input  1  kill all held entries and drop same-cycle input (branch/jump redirect)
i_d_valid  input  1  decode presents an instruction
o_d_ready  output  1  boundary can accept this cycle
i_d_payload  input  PAYLOAD_W  decoded bundle
i_d_rs1_addr  input  5  source register 1 of incoming instruction
i_d_rs2_addr  input  5  source register 2 of incoming instruction
i_d_rs1_use  input  1  incoming instruction reads rs1
i_d_rs2_use  input  1  incoming instruction reads rs2
i_d_rd_addr  input  5  destination register of incoming instruction
i_d_rd_wren  input  1  incoming instruction writes rd
i_d_is_load  input  1  incoming instruction is a load
o_e_valid  output  1  execute-side entry valid
i_e_ready  input  1  execute consumes the entry this cycle
o_e_payload  output  PAYLOAD_W  bundle of the oldest held entry
o_e_rd_addr  output  5  rd of the oldest held entry
o_e_rd_wren  output  1  rd_wren of the oldest held entry
o_e_is_load  output  1  is_load of the oldest held entry
o_hazard  output  1  load-use interlock is active this cycle
o_stall_cnt  output  CNT_W  cycles blocked by load-use interlock
o_flush_cnt  output  CNT_W  valid entries killed by flush

Behaviour:
- Reset: all valid flags 0; payload and sideband registers 0; o_e_valid, o_e_rd_addr, o_e_rd_wren, o_e_is_load, o_hazard 0; counters 0. o_d_ready is 1 from the first cycle after reset.
- Entry: payload plus rd_addr, rd_wren, is_load. Main entry drives the o_e_* outputs; the skid entry exists only when SKID=1.
- States (SKID=1):
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - TWO: both valid.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept with no consume → TWO.
  - ONE + consume with no accept → EMPTY.
  - ONE + accept and consume → ONE (new entry enters main).
  - TWO + consume → ONE (skid moves to main).
  - TWO never accepts.
- Ready:
  - SKID=1: o_d_ready = !skid_valid && !o_hazard. This is a registered-state function only, with no path from i_e_ready.
  - SKID=0: o_d_ready = (!main_valid || i_e_ready) && !o_hazard.
- Accept = i_d_valid && o_d_ready && !i_flush. Consume = o_e_valid && i_e_ready.
- Latency: an accepted instruction appears on o_e_* the next cycle. Sustained throughput is 1/cycle while i_e_ready=1 and no hazard.
- Stability: while o_e_valid && !i_e_ready, o_e_payload and the o_e_* sideband hold constant.
- Load-use interlock:
  - Youngest held entry = skid if valid, else main.
  - o_hazard = i_d_valid && youngest valid && youngest.is_load && youngest.rd_wren && youngest.rd_addr != 0 && ((i_d_rs1_use && rs1 == rd) || (i_d_rs2_use && rs2 == rd)).
  - Effect: a dependent instruction enters only after the load has left the boundary, guaranteeing at least one bubble.
- Flush:
  - i_flush clears both valid flags at the clock edge and drops that cycle's input.
  - Flush has priority over accept and consume. A same-cycle i_e_ready handshake still counts as consumed by execute.
  - Flush during reset is ignored; reset wins.
- Counters:
  - o_stall_cnt +1 on each cycle with o_hazard=1 and no flush.
  - o_flush_cnt += number of valid entries that are not consumed at a flush edge (0, 1 or 2).
  - Both saturate at 2^CNT_W−1, with no wrap.
- Reset mid-operation: all entries discarded; counters return to 0.
- x0: a load with rd=0 never triggers the interlock.

Test Plan:
- Streaming, SKID=1: 8 back-to-back instructions with i_e_ready=1 → payloads appear in order, one cycle after each accept, with no gaps; o_stall_cnt=0.
- Backpressure: i_e_ready=0 for 3 cycles while valid is held → main and skid fill, o_d_ready=0 from the 2nd cycle, o_e_payload constant. Then release → both drain in order with no loss or duplication.
- Load-use: load x5 followed by add x6,x5,x7 → o_hazard=1 for exactly 1 cycle while the load sits in E with i_e_ready=1, the add appears one cycle after the load leaves, and o_stall_cnt=1. Repeating with rd=x0 → no stall.
- Flush with TWO entries and i_e_ready=0, with i_d_valid=1 on the flush cycle → o_e_valid=0 next cycle, the input is dropped, and o_flush_cnt=2.
- Reset during TWO → all outputs 0 next cycle, o_d_ready=1. Saturation: force 2^CNT_W+3 stall cycles → o_stall_cnt=2^CNT_W−1.
- SKID=0 build: i_e_ready toggling every cycle → o_d_ready follows i_e_ready combinationally when main is valid, and ordering is preserved.
